vocal_band_filter_mc: RTL and testbench

- Multi-channel, parametrised bandpass / band-reject filter for the I2S audio path. Sits between the I2S receiver and the output mixer.
- Each channel keeps its own pair of one-pole low-pass states: a fast one (LP) and a slow one (HP). Bandpass = LP − HP.
- Adds band-reject, mute, runtime gain, output saturation and a saturation counter.
- Mode and gain changes are frame-aligned so all channels switch coherently.

---
 rtl/vocal_band_filter_mc.sv | 143 ++++++++++++++
 tb/tb_vocal_band_filter_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vocal_band_filter_mc.sv
// vocal_band_filter_mc: per-channel one-pole LP/HP bandpass / band-reject filter with gain and saturation.
// Two-stage pipeline; mode and gain switch only on channel-0 samples.
module vocal_band_filter_mc #(
    parameter int DATA_W   = 24,
    parameter int NUM_CH   = 2,
    parameter int LP_SHIFT = 1,
    parameter int HP_SHIFT = 5,
    parameter int CH_W     = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     data_in,
    input  logic            data_valid,
    input  logic [CH_W-1:0] ch_in,
    input  logic [1:0]      mode,
    input  logic [1:0]      gain_shl,
    input  logic            clear_state,
    output logic [31:0]     data_out,
    output logic            data_valid_out,
    output logic [CH_W-1:0] ch_out,
    output logic [15:0]     sat_cnt
);
    localparam int IW = DATA_W + 2;
    localparam int YW = IW + 4;
    localparam int NS = 2 ** CH_W;

    logic signed [IW-1:0] lp_q [NS];
    logic signed [IW-1:0] hp_q [NS];
    logic [1:0]           mode_q, gain_q;

    logic                 s1_vld_q, s1_rng_q;
    logic [CH_W-1:0]      s1_ch_q;
    logic [31:0]          s1_raw_q;
    logic signed [IW-1:0] s1_x_q, s1_bp_q;
    logic [1:0]           s1_mode_q, s1_gain_q;

    logic [31:0]          dout_q;
    logic                 vld_q;
    logic [CH_W-1:0]      ch_q;
    logic [15:0]          sat_q;

    logic                 in_rng, ch0;
    logic signed [IW-1:0] x, lp_cur, hp_cur, lp_d, hp_d;

    // A coincident clear makes this sample start from zero state
    assign in_rng = {1'b0, ch_in} < (CH_W+1)'(NUM_CH);
    assign ch0    = ch_in == '0;
    assign x      = {{2{data_in[DATA_W-1]}}, data_in[DATA_W-1:0]};
    assign lp_cur = clear_state ? '0 : lp_q[ch_in];
    assign hp_cur = clear_state ? '0 : hp_q[ch_in];
    assign lp_d   = lp_cur + ((x - lp_cur) >>> LP_SHIFT);
    assign hp_d   = hp_cur + ((x - hp_cur) >>> HP_SHIFT);

    logic signed [YW-1:0] x_e, bp_e, y;
    logic                 hi, lo, filt, clip;
    logic [DATA_W-1:0]    sat_v;
    logic [31:0]          dout_d;

    assign x_e    = {{4{s1_x_q[IW-1]}}, s1_x_q};
    assign bp_e   = {{4{s1_bp_q[IW-1]}}, s1_bp_q};
    assign y      = (s1_mode_q == 2'b01 ? bp_e : x_e - bp_e) <<< s1_gain_q;
    assign hi     = y > $signed({{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    assign lo     = y < $signed({{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});
    assign filt   = s1_mode_q[0] ^ s1_mode_q[1];
    assign sat_v  = hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : y[DATA_W-1:0];
    assign dout_d = !s1_rng_q ? '0 :
                    s1_mode_q == 2'b00 ? s1_raw_q :
                    filt ? {{(32-DATA_W){sat_v[DATA_W-1]}}, sat_v} : '0;
    assign clip   = s1_vld_q && s1_rng_q && filt && (hi || lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                lp_q[i] <= '0;
                hp_q[i] <= '0;
            end
        end else begin
            if (clear_state)
                for (int i = 0; i < NS; i++) begin
                    lp_q[i] <= '0;
                    hp_q[i] <= '0;
                end
            if (data_valid && in_rng) begin
                lp_q[ch_in] <= lp_d;
                hp_q[ch_in] <= hp_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 2'b00;
            gain_q    <= 2'b00;
            s1_vld_q  <= 1'b0;
            s1_rng_q  <= 1'b0;
            s1_ch_q   <= '0;
            s1_raw_q  <= '0;
            s1_x_q    <= '0;
            s1_bp_q   <= '0;
            s1_mode_q <= 2'b00;
            s1_gain_q <= 2'b00;
        end else begin
            s1_vld_q <= data_valid;
            if (data_valid && ch0) begin
                mode_q <= mode;
                gain_q <= gain_shl;
            end
            if (data_valid) begin
                s1_rng_q  <= in_rng;
                s1_ch_q   <= ch_in;
                s1_raw_q  <= data_in;
                s1_x_q    <= x;
                s1_bp_q   <= lp_d - hp_d;
                s1_mode_q <= ch0 ? mode : mode_q;
                s1_gain_q <= ch0 ? gain_shl : gain_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
            ch_q   <= '0;
            sat_q  <= '0;
        end else begin
            vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                dout_q <= dout_d;
                ch_q   <= s1_ch_q;
            end
            if (clear_state)
                sat_q <= '0;
            else if (clip && sat_q != 16'hFFFF)
                sat_q <= sat_q + 16'd1;
        end
    end

    assign data_out       = dout_q;
    assign data_valid_out = vld_q;
    assign ch_out         = ch_q;
    assign sat_cnt        = sat_q;
endmodule

// File: tb/tb_vocal_band_filter_mc.sv
// tb_vocal_band_filter_mc: directed plus randomized checks of vocal_band_filter_mc against an arithmetic model.
module tb_vocal_band_filter_mc;
    localparam int NUM_CH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        data_valid;
    logic [2:0]  ch_in;
    logic [1:0]  mode;
    logic [1:0]  gain_shl;
    logic        clear_state;
    logic [31:0] data_out;
    logic        data_valid_out;
    logic [2:0]  ch_out;
    logic [15:0] sat_cnt;

    vocal_band_filter_mc dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .ch_in(ch_in), .mode(mode), .gain_shl(gain_shl), .clear_state(clear_state),
        .data_out(data_out), .data_valid_out(data_valid_out), .ch_out(ch_out), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [2:0]  ch;
        logic [31:0] dout;
        logic        clip;
    } exp_t;

    int          n_pass = 0;
    int          n_total = 0;
    longint      lpm [8];
    longint      hpm [8];
    logic [1:0]  am, ag;
    logic [15:0] satm;
    exp_t        prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    function automatic longint fdiv(input longint a, input int s);
        longint d = longint'(1) << s;
        longint q = a / d;
        if (a < 0 && q * d != a) q--;
        return q;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            lpm[i] = 0;
            hpm[i] = 0;
        end
        am = 2'b00;
        ag = 2'b00;
        satm = 16'h0;
        prev = '{1'b0, 3'd0, 32'd0, 1'b0};
    endtask

    task automatic cyc(input logic v, input logic [2:0] ch, input logic [31:0] d,
                       input logic [1:0] m, input logic [1:0] g, input logic clr);
        exp_t   r;
        longint xv, bp, yv;
        logic [1:0] em, eg;
        @(negedge clk);
        data_valid = v; ch_in = ch; data_in = d; mode = m; gain_shl = g; clear_state = clr;
        if (clr)
            for (int i = 0; i < 8; i++) begin
                lpm[i] = 0;
                hpm[i] = 0;
            end
        r = '{v, ch, 32'd0, 1'b0};
        if (v) begin
            if (ch == 3'd0) begin
                am = m;
                ag = g;
            end
            em = am;
            eg = ag;
            if (int'(ch) < NUM_CH) begin
                xv = d[23] ? longint'(d[23:0]) - (longint'(1) << 24) : longint'(d[23:0]);
                lpm[ch] = lpm[ch] + fdiv(xv - lpm[ch], 1);
                hpm[ch] = hpm[ch] + fdiv(xv - hpm[ch], 5);
                bp = lpm[ch] - hpm[ch];
                if (em == 2'b00) r.dout = d;
                else if (em == 2'b11) r.dout = 32'd0;
                else begin
                    yv = (em == 2'b01 ? bp : xv - bp) * (longint'(1) << eg);
                    if (yv > 8388607) begin yv = 8388607; r.clip = 1'b1; end
                    if (yv < -8388608) begin yv = -8388608; r.clip = 1'b1; end
                    r.dout = yv[31:0];
                end
            end
        end
        @(posedge clk);
        #1;
        if (clr) satm = 16'h0;
        else if (prev.clip && satm != 16'hFFFF) satm++;
        chk("valid_out", 32'(data_valid_out), 32'(prev.vld));
        if (prev.vld) begin
            chk("ch_out", 32'(ch_out), 32'(prev.ch));
            chk("data_out", data_out, prev.dout);
        end
        chk("sat_cnt", 32'(sat_cnt), 32'(satm));
        prev = r;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 32'd0, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        data_valid = 1'b0; ch_in = '0; data_in = '0; mode = '0; gain_shl = '0; clear_state = 1'b0;
        model_reset();
        // reset held under random activity
        repeat (4) begin
            @(negedge clk);
            data_valid = 1'b1; ch_in = 3'($urandom_range(0, 1)); data_in = $urandom;
            mode = 2'($urandom_range(0, 3)); gain_shl = 2'($urandom_range(0, 3)); clear_state = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("rst_dout", data_out, 32'd0);
            chk("rst_vld", 32'(data_valid_out), 32'd0);
            chk("rst_sat", 32'(sat_cnt), 32'd0);
        end
        @(negedge clk);
        data_valid = 1'b0; clear_state = 1'b0; mode = '0; gain_shl = '0;
        rst_n = 1'b1;
        repeat (3) begin
            idle();
            chk("post_rst_dout", data_out, 32'd0);
        end

        // bandpass, single channel
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b01, 2'd0, 1'b0);
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b01, 2'd0, 1'b0);
        chk("bp_first", data_out, 32'h0000_7800);
        idle();
        chk("bp_second", data_out, 32'h0000_B040);

        // band-reject from cleared state
        cyc(1'b0, 3'd0, 32'd0, 2'b10, 2'd0, 1'b1);
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b10, 2'd0, 1'b0);
        idle();
        chk("br_first", data_out, 32'h0000_8800);

        // interleaved channels keep separate state
        cyc(1'b0, 3'd0, 32'd0, 2'b01, 2'd0, 1'b1);
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b01, 2'd0, 1'b0);
        cyc(1'b1, 3'd1, 32'h0000_0000, 2'b01, 2'd0, 1'b0);
        chk("il_ch0", data_out, 32'h0000_7800);
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b01, 2'd0, 1'b0);
        chk("il_ch1_ch", 32'(ch_out), 32'd1);
        chk("il_ch1_dout", data_out, 32'd0);
        idle();
        chk("il_ch0_iso", data_out, 32'h0000_B040);

        // saturation at both rails
        cyc(1'b0, 3'd0, 32'd0, 2'b01, 2'd0, 1'b1);
        cyc(1'b1, 3'd0, 32'h007F_FFFF, 2'b01, 2'd3, 1'b0);
        cyc(1'b1, 3'd0, 32'h0080_0000, 2'b01, 2'd3, 1'b0);
        chk("sat_hi", data_out, 32'h007F_FFFF);
        chk("sat_cnt1", 32'(sat_cnt), 32'd1);
        idle();
        chk("sat_lo", data_out, 32'hFF80_0000);
        chk("sat_cnt2", 32'(sat_cnt), 32'd2);

        // mode change mid-frame waits for the next channel-0 sample
        cyc(1'b1, 3'd0, 32'h0001_0000, 2'b01, 2'd0, 1'b0);
        cyc(1'b1, 3'd1, 32'h0001_0000, 2'b00, 2'd0, 1'b0);
        cyc(1'b1, 3'd0, 32'hAB12_3456, 2'b00, 2'd0, 1'b0);
        chk("mc_ch1_filt", data_out, 32'h0000_7800);
        idle();
        chk("mc_bypass", data_out, 32'hAB12_3456);
        cyc(1'b0, 3'd0, 32'd0, 2'b00, 2'd0, 1'b1);
        chk("clr_sat", 32'(sat_cnt), 32'd0);

        // clear coincident with a clipping sample
        cyc(1'b1, 3'd0, 32'h007F_FFFF, 2'b01, 2'd3, 1'b0);
        cyc(1'b1, 3'd0, 32'h007F_FFFF, 2'b01, 2'd3, 1'b1);
        idle();
        chk("clr_coinc_dout", data_out, 32'h007F_FFFF);
        chk("clr_coinc_sat", 32'(sat_cnt), 32'd1);

        // out-of-range channel
        cyc(1'b1, 3'd5, 32'h0012_3456, 2'b01, 2'd0, 1'b0);
        idle();
        chk("oor_vld", 32'(data_valid_out), 32'd1);
        chk("oor_ch", 32'(ch_out), 32'd5);
        chk("oor_dout", data_out, 32'd0);

        // reset while a sample is in flight
        cyc(1'b1, 3'd0, 32'h0012_3456, 2'b00, 2'd0, 1'b0);
        @(negedge clk);
        data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld0", 32'(data_valid_out), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_vld1", 32'(data_valid_out), 32'd0);
        chk("midrst_sat", 32'(sat_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (2) idle();

        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 3)), $urandom,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 30) == 0));
        repeat (2) idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
